// File: rtl/writeback_pkg.sv
// Shared definitions for the write-back stage: default widths, the hard-wired
// zero register index and the pending-write entry layout.
package writeback_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [ADDR_W_DEF-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Circular FIFO of pending register writes. Exposes its head, every slot with a
// per-slot valid bit, and the oldest slot index so callers can walk entries by age.
module wb_queue
  import writeback_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  entry_t                     i_din,
  input  logic                       i_pop,
  output entry_t                     o_head,
  output entry_t [DEPTH-1:0]         o_slots,
  output logic   [DEPTH-1:0]         o_slot_valid,
  output logic   [$clog2(DEPTH)-1:0] o_oldest,
  output logic   [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic   [PW-1:0]    r_wr_ptr;
  logic   [PW-1:0]    r_rd_ptr;
  logic   [PW:0]      r_count;
  logic   [DEPTH-1:0] r_valid;
  entry_t [DEPTH-1:0] r_mem;

  logic w_push;
  logic w_pop;

  // Guarded here too, so a careless caller can never overrun or underrun.
  assign w_push = i_push && (r_count != (PW+1)'(DEPTH));
  assign w_pop  = i_pop  && (r_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: r_valid and r_count decide what is visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head       = r_mem[r_rd_ptr];
  assign o_slots      = r_mem;
  assign o_slot_valid = r_valid;
  assign o_oldest     = r_rd_ptr;
  assign o_count      = r_count;

endmodule

// File: rtl/writeback_stage.sv
// Register-file write side: selects the write-back value, queues pending writes,
// drains one per cycle to the register file, and forwards uncommitted results.
module writeback_stage
  import writeback_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_rd,
  input  logic                     RegWrite,
  input  logic                     MemtoReg,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic [DATA_W-1:0]        ALU_Result,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic                     rf_ready,
  input  logic [ADDR_W-1:0]        fwd_addr1,
  input  logic [ADDR_W-1:0]        fwd_addr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int QW = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t               w_din;
  entry_t               w_head;
  entry_t [DEPTH-1:0]   w_slots;
  logic   [DEPTH-1:0]   w_slot_valid;
  logic   [QW-1:0]      w_oldest;
  logic   [QW:0]        w_count;
  logic   [QW-1:0]      w_age_idx [DEPTH];
  logic                 w_accept;
  logic                 w_enq;
  logic                 w_pop;

  // Handshake: a request transfers on a rising edge where wb_valid && wb_ready;
  // a write transfers to the register file on an edge where rf_we && rf_ready.
  assign wb_ready = (w_count != (QW+1)'(DEPTH));
  assign w_accept = wb_valid && wb_ready;
  assign w_enq    = w_accept && RegWrite && (wb_rd != ADDR_W'(ZERO_REG));
  assign w_din    = '{rd: wb_rd, data: (MemtoReg ? mem_data : ALU_Result)};
  assign w_pop    = rf_we && rf_ready;

  wb_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_enq),
    .i_din        (w_din),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_slots      (w_slots),
    .o_slot_valid (w_slot_valid),
    .o_oldest     (w_oldest),
    .o_count      (w_count)
  );

  assign pending  = w_count;
  assign rf_we    = (w_count != '0);
  assign rf_waddr = rf_we ? w_head.rd   : '0;
  assign rf_wdata = rf_we ? w_head.data : '0;

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign w_age_idx[k] = w_oldest + QW'(k);
  end

  // Walks oldest to youngest and lets later matches overwrite, so the youngest
  // pending value for a register is the one forwarded.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_slot_valid[w_age_idx[k]] && (fwd_addr1 != '0) &&
          (w_slots[w_age_idx[k]].rd == fwd_addr1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = w_slots[w_age_idx[k]].data;
      end
      if (w_slot_valid[w_age_idx[k]] && (fwd_addr2 != '0) &&
          (w_slots[w_age_idx[k]].rd == fwd_addr2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = w_slots[w_age_idx[k]].data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus a random phase, all checked
// every cycle against a queue-of-pending-writes reference model.
module tb_writeback_stage;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int PW    = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          wb_valid, wb_ready, RegWrite, MemtoReg;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] mem_data, ALU_Result;
  logic          rf_we, rf_ready;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] fwd_addr1, fwd_addr2;
  logic          fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;
  logic [PW-1:0] pending;

  writeback_stage #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .RegWrite   (RegWrite),
    .MemtoReg   (MemtoReg),
    .mem_data   (mem_data),
    .ALU_Result (ALU_Result),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_ready   (rf_ready),
    .fwd_addr1  (fwd_addr1),
    .fwd_addr2  (fwd_addr2),
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2),
    .pending    (pending)
  );

  // scoreboard: pending writes in acceptance order, each {rd, data}
  logic [AW+DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest pending value for a register, or {0,0} when nothing matches.
  function automatic logic [DW:0] fwd_model(input logic [AW-1:0] a);
    if (a == '0) return '0;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i][AW+DW-1:DW] == a) return {1'b1, exp_q[i][DW-1:0]};
    return '0;
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic [AW-1:0] rd, input logic rw,
                       input logic m2r, input logic [DW-1:0] mem, input logic [DW-1:0] alu);
    wb_valid   = v;
    wb_rd      = rd;
    RegWrite   = rw;
    MemtoReg   = m2r;
    mem_data   = mem;
    ALU_Result = alu;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // One clock: inputs already applied after a falling edge; check all outputs
  // against the model, take the rising edge, then advance the model.
  task automatic cycle(output bit accepted);
    logic [AW+DW-1:0] head;
    logic [DW:0]      f1, f2;
    bit               do_pop, do_push;
    logic [AW+DW-1:0] ent;
    #1;
    assert (!(wb_valid && $isunknown(MemtoReg))) else begin
      errors++;
      $error("FAIL memtoreg_x: observed %b expected 0/1", MemtoReg);
    end
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    f1   = fwd_model(fwd_addr1);
    f2   = fwd_model(fwd_addr2);
    check("wb_ready",  wb_ready,  exp_q.size() != DEPTH);
    check("pending",   pending,   exp_q.size());
    check("rf_we",     rf_we,     exp_q.size() != 0);
    check("rf_waddr",  rf_waddr,  head[AW+DW-1:DW]);
    check("rf_wdata",  rf_wdata,  head[DW-1:0]);
    check("fwd_hit1",  fwd_hit1,  f1[DW]);
    check("fwd_data1", fwd_data1, f1[DW-1:0]);
    check("fwd_hit2",  fwd_hit2,  f2[DW]);
    check("fwd_data2", fwd_data2, f2[DW-1:0]);
    accepted = wb_valid && (exp_q.size() != DEPTH);
    do_pop   = (exp_q.size() != 0) && rf_ready;
    do_push  = accepted && RegWrite && (wb_rd != '0);
    ent      = {wb_rd, (MemtoReg ? mem_data : ALU_Result)};
    @(posedge clk);
    if (do_pop)  void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(ent);
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    idle();
    rf_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 2; i++) cycle(acc);
  endtask

  initial begin
    bit acc;
    int tries;
    reset = 1'b1;
    idle();
    rf_ready  = 1'b1;
    fwd_addr1 = '0;
    fwd_addr2 = '0;

    // reset state
    #2;
    check("rst_rf_we",    rf_we,    1'b0);
    check("rst_pending",  pending,  '0);
    check("rst_wb_ready", wb_ready, 1'b1);
    check("rst_rf_wdata", rf_wdata, '0);
    check("rst_fwd_hit1", fwd_hit1, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // basic select: ALU then memory data
    drive(1'b1, 5'd3, 1'b1, 1'b0, 32'h0, 32'h15);
    cycle(acc);
    drive(1'b1, 5'd7, 1'b1, 1'b1, 32'hDEADBEEF, 32'h1234);
    cycle(acc);
    drain();

    // filtering: rd=0 and RegWrite=0 are consumed but not queued
    drive(1'b1, 5'd0, 1'b1, 1'b0, 32'h0, 32'hAA);
    cycle(acc);
    check("filter_acc_rd0", acc, 1'b1);
    drive(1'b1, 5'd9, 1'b0, 1'b0, 32'h0, 32'hBB);
    cycle(acc);
    check("filter_acc_nowr", acc, 1'b1);
    drain();

    // backpressure: fill, stall the 5th, release the register file
    rf_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, AW'(i), 1'b1, 1'b0, 32'h0, 32'h100 + i);
      if (i == 5) begin
        rf_ready = 1'b1;
        tries = 0;
        do begin
          cycle(acc);
          tries++;
        end while (!acc && tries < 8);
        check("bp_fifth_accepted", acc, 1'b1);
        check("bp_fifth_tries", tries, 2);
      end else begin
        cycle(acc);
      end
    end
    drain();

    // forwarding: youngest of two writes to r25 wins, r20 misses
    rf_ready = 1'b0;
    fwd_addr1 = 5'd25;
    fwd_addr2 = 5'd20;
    drive(1'b1, 5'd25, 1'b1, 1'b0, 32'h0, 32'd15);
    cycle(acc);
    drive(1'b1, 5'd25, 1'b1, 1'b1, 32'd40, 32'h0);
    cycle(acc);
    idle();
    cycle(acc);
    check("fwd_young_hit",  fwd_hit1,  1'b1);
    check("fwd_young_data", fwd_data1, 32'd40);
    check("fwd_miss_hit",   fwd_hit2,  1'b0);
    drain();

    // wrap and throughput: 20 back-to-back writes
    rf_ready = 1'b1;
    fwd_addr1 = 5'd4;
    fwd_addr2 = 5'd17;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, AW'(i), 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      cycle(acc);
      check("wrap_accept", acc, 1'b1);
    end
    drain();

    // reset mid-operation with three entries queued
    rf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(10 + i), 1'b1, 1'b0, 32'h0, $urandom);
      cycle(acc);
    end
    idle();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_rf_we",   rf_we,   1'b0);
    check("midrst_pending", pending, '0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    rf_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle(acc);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)),
            1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom);
      rf_ready  = 1'($urandom_range(0, 3) != 0);
      fwd_addr1 = AW'($urandom_range(0, 7));
      fwd_addr2 = AW'($urandom_range(0, 7));
      cycle(acc);
    end
    drain();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
